// File: rtl/shift_reg_ctrl_pkg.sv
// Shared types and defaults for the serial shift-register sequencing controller.
package shift_ctrl_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_GAP   = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/shift_reg_ctrl_down_counter.sv
// Loadable down counter; `last` flags that the next enabled decrement empties it.
module down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         last
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign last = (count_reg == W'(1));

endmodule

// File: rtl/shift_reg_ctrl.sv
// Accepts parallel words over valid/ready and shifts them MSB-first to a serial-in register.
module shift_reg_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GAP   = DEF_GAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  input  logic             hold,
  output logic             ser_out,
  output logic             shift_en,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] buf_reg;
  logic             frame_done_reg;
  logic             accept;
  logic             bit_last;
  logic             gap_last;
  logic             frame_end;

  assign word_ready = (state_reg == ST_IDLE) && !reset;
  assign shift_en   = (state_reg == ST_SHIFT) && !hold && !reset;
  assign ser_out    = buf_reg[WIDTH-1];
  assign busy       = (state_reg != ST_IDLE);
  assign frame_done = frame_done_reg;
  assign accept     = word_valid && word_ready;
  assign frame_end  = shift_en && bit_last;

  down_counter #(.W(CW)) u_bit_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (CW'(WIDTH)),
    .en       (shift_en),
    .last     (bit_last)
  );

  // With no gap the GAP state is unreachable, so its counter is not built.
  generate
    if (GAP > 0) begin : g_gap
      down_counter #(.W(GW)) u_gap_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (frame_end),
        .load_val (GW'(GAP)),
        .en       (state_reg == ST_GAP),
        .last     (gap_last)
      );
    end else begin : g_no_gap
      assign gap_last = 1'b1;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (accept) state_next = ST_SHIFT;
      ST_SHIFT: if (frame_end) state_next = (GAP > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:   if (gap_last) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      buf_reg        <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      frame_done_reg <= frame_end;
      if (accept) begin
        buf_reg <= word_in;
      end else if (shift_en) begin
        buf_reg <= buf_reg << 1;
      end
    end
  end

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Directed bench: WIDTH=4/GAP=1 controller feeding a 4-bit serial-in register, plus a WIDTH=1/GAP=0 instance.
module tb_shift_reg_ctrl;

  logic       clk = 1'b0;
  logic       reset, word_valid, hold, word_ready, ser_out, shift_en, frame_done, busy;
  logic [3:0] word_in;
  logic       reset_b, word_valid_b, hold_b, word_ready_b, ser_out_b, shift_en_b, frame_done_b, busy_b;
  logic [0:0] word_in_b;
  logic [3:0] sr_reg;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  shift_reg_ctrl #(.WIDTH(4), .GAP(1)) dut (
    .clk(clk), .reset(reset), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .hold(hold), .ser_out(ser_out), .shift_en(shift_en),
    .frame_done(frame_done), .busy(busy)
  );

  shift_reg_ctrl #(.WIDTH(1), .GAP(0)) dut_b (
    .clk(clk), .reset(reset_b), .word_in(word_in_b), .word_valid(word_valid_b),
    .word_ready(word_ready_b), .hold(hold_b), .ser_out(ser_out_b), .shift_en(shift_en_b),
    .frame_done(frame_done_b), .busy(busy_b)
  );

  // Downstream serial-in register
  always_ff @(posedge clk) begin
    if (reset) sr_reg <= 4'b0;
    else if (shift_en) sr_reg <= {sr_reg[2:0], ser_out};
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] w_a, w_b;
    logic [7:0] sh_tab, ser_tab;
    w_a = 4'b1011;
    w_b = 4'b0101;
    sh_tab  = 8'b0111_0010;
    ser_tab = 8'b0110_0010;
    reset = 1'b1; word_valid = 1'b0; hold = 1'b0; word_in = 4'b0;
    reset_b = 1'b1; word_valid_b = 1'b0; hold_b = 1'b0; word_in_b = 1'b0;

    // Reset for two cycles
    next_cycle(); #3;
    check_eq("rst_ready", word_ready, 0);
    check_eq("rst_shift_en", shift_en, 0);
    next_cycle();
    next_cycle(); reset = 1'b0; reset_b = 1'b0; #3;
    check_eq("idle_ready", word_ready, 1);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_shift_en", shift_en, 0);
    check_eq("idle_frame_done", frame_done, 0);
    check_eq("idle_ser_out", ser_out, 0);
    $display("txn reset: ready=%0b busy=%0b", word_ready, busy);

    // Plain frame 1011
    next_cycle(); word_valid = 1'b1; word_in = w_a; #3;
    check_eq("f1_c0_ready", word_ready, 1);
    for (int i = 1; i <= 4; i++) begin
      next_cycle(); word_valid = 1'b0; #3;
      check_eq("f1_shift_en", shift_en, 1);
      check_eq("f1_ser_out", ser_out, w_a[4-i]);
      check_eq("f1_no_done", frame_done, 0);
    end
    next_cycle(); #3;
    check_eq("f1_c5_done", frame_done, 1);
    check_eq("f1_c5_shift_en", shift_en, 0);
    check_eq("f1_c5_ready", word_ready, 0);
    check_eq("f1_c5_busy", busy, 1);
    next_cycle(); #3;
    check_eq("f1_c6_ready", word_ready, 1);
    check_eq("f1_c6_done", frame_done, 0);
    check_eq("f1_downstream", sr_reg, 4'b1011);
    $display("txn frame word=%b downstream=%b", w_a, sr_reg);

    // Same word with hold in c2..c3
    next_cycle(); word_valid = 1'b1; word_in = w_a; #3;
    check_eq("f2_c0_ready", word_ready, 1);
    for (int c = 1; c <= 7; c++) begin
      next_cycle(); word_valid = 1'b0; hold = (c == 2 || c == 3); #3;
      check_eq("f2_shift_en", shift_en, sh_tab[c]);
      check_eq("f2_ser_out", ser_out, ser_tab[c]);
      check_eq("f2_frame_done", frame_done, (c == 7) ? 1 : 0);
    end
    next_cycle(); hold = 1'b0; #3;
    check_eq("f2_c8_ready", word_ready, 1);
    check_eq("f2_downstream", sr_reg, 4'b1011);
    $display("txn hold-frame word=%b downstream=%b", w_a, sr_reg);

    // Back-to-back with word_valid held high
    next_cycle(); word_valid = 1'b1; word_in = w_a; #3;
    check_eq("b2b_c0_ready", word_ready, 1);
    for (int c = 1; c <= 5; c++) begin
      next_cycle(); word_in = w_b; #3;
      check_eq("b2b_not_ready", word_ready, 0);
      if (c <= 4) check_eq("b2b_first_ser", ser_out, w_a[4-c]);
    end
    next_cycle(); #3;
    check_eq("b2b_c6_ready", word_ready, 1);
    for (int i = 1; i <= 4; i++) begin
      next_cycle(); word_valid = 1'b0; #3;
      check_eq("b2b_second_shift_en", shift_en, 1);
      check_eq("b2b_second_ser", ser_out, w_b[4-i]);
    end
    next_cycle(); #3;
    check_eq("b2b_c11_done", frame_done, 1);
    next_cycle(); #3;
    check_eq("b2b_c12_ready", word_ready, 1);
    check_eq("b2b_downstream", sr_reg, 4'b0101);
    $display("txn back-to-back words=%b,%b downstream=%b", w_a, w_b, sr_reg);

    // Reset pulse mid-frame
    next_cycle(); word_valid = 1'b1; word_in = w_a; #3;
    check_eq("abort_c0_ready", word_ready, 1);
    next_cycle(); word_valid = 1'b0; #3;
    check_eq("abort_c1_ser", ser_out, 1);
    next_cycle(); reset = 1'b1; #3;
    check_eq("abort_c2_shift_en", shift_en, 0);
    check_eq("abort_c2_ready", word_ready, 0);
    next_cycle(); reset = 1'b0; #3;
    check_eq("abort_c3_ready", word_ready, 1);
    check_eq("abort_c3_busy", busy, 0);
    check_eq("abort_c3_ser", ser_out, 0);
    for (int c = 3; c <= 6; c++) begin
      if (c > 3) begin next_cycle(); #3; end
      check_eq("abort_no_shift", shift_en, 0);
      check_eq("abort_no_done", frame_done, 0);
    end
    $display("txn abort: busy=%0b ready=%0b", busy, word_ready);

    // WIDTH=1, GAP=0 instance
    next_cycle(); word_valid_b = 1'b1; word_in_b = 1'b1; #3;
    check_eq("w1_c0_ready", word_ready_b, 1);
    next_cycle(); word_valid_b = 1'b0; #3;
    check_eq("w1_c1_shift_en", shift_en_b, 1);
    check_eq("w1_c1_ser", ser_out_b, 1);
    check_eq("w1_c1_busy", busy_b, 1);
    check_eq("w1_c1_ready", word_ready_b, 0);
    next_cycle(); #3;
    check_eq("w1_c2_done", frame_done_b, 1);
    check_eq("w1_c2_ready", word_ready_b, 1);
    check_eq("w1_c2_shift_en", shift_en_b, 0);
    next_cycle(); #3;
    check_eq("w1_c3_done", frame_done_b, 0);
    $display("txn w1-frame bit=%b", word_in_b);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
